// File: rtl/dff_link_arbiter_if.sv
// Requester and delivery port bundle for dff_link_arbiter.
// The slave side is the arbiter. The master side drives the requests and the output ready.
interface dff_link_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/dff_link_arbiter.sv
// Round-robin sharing of a 4-stage DFF delay link between two requesters.
// The output tap is selectable (1-4 stages), and the whole link stalls when the output is back-pressured.
module dff_link_arbiter #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  dff_link_arbiter_if.slave    link,
  input  logic [1:0]           cfg_depth,
  input  logic                 flush,
  output logic [1:0]           active_depth,
  output logic [2:0]           occupancy,
  output logic                 busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  typedef struct packed {
    logic             v;
    logic             src;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t     s_q [STAGES];
  stage_t     s_d [STAGES];
  state_t     state_q, state_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic [1:0] active_depth_q, active_depth_d;

  logic       advance;
  logic       can_grant;
  logic       grant_a;
  logic       grant_b;
  logic       grant_any;
  logic [2:0] occ;

  // The whole link freezes only when the tap holds a byte that downstream refuses.
  assign advance   = !(s_q[active_depth_q].v && !link.out_ready);
  assign can_grant = advance && (state_q != ST_DRAIN) && !flush && !RST;
  assign grant_a   = can_grant && link.a_valid && (!link.b_valid || !rr_ptr_q);
  assign grant_b   = can_grant && link.b_valid && (!link.a_valid ||  rr_ptr_q);
  assign grant_any = grant_a || grant_b;

  assign link.a_ready   = grant_a;
  assign link.b_ready   = grant_b;
  assign link.out_valid = s_q[active_depth_q].v;
  assign link.out_data  = s_q[active_depth_q].data;
  assign link.out_src   = s_q[active_depth_q].src;

  always_comb begin
    occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + 3'(s_q[k].v);
    end
  end

  assign occupancy    = occ;
  assign active_depth = active_depth_q;
  assign busy         = (state_q != ST_IDLE);

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_d[k] = s_q[k];
    end
    if (advance) begin
      s_d[0].v    = grant_any;
      s_d[0].src  = grant_b;
      s_d[0].data = grant_b ? link.b_data : link.a_data;
      // Stages past the tap never carry a live byte.
      for (int k = 1; k < STAGES; k++) begin
        if (k <= int'(active_depth_q)) begin
          s_d[k] = s_q[k-1];
        end else begin
          s_d[k].v = 1'b0;
        end
      end
    end
    if (flush) begin
      for (int k = 0; k < STAGES; k++) begin
        s_d[k].v = 1'b0;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    active_depth_d = active_depth_q;
    if (grant_a) begin
      rr_ptr_d = 1'b1;
    end else if (grant_b) begin
      rr_ptr_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        // A grant keeps the old depth so the new byte exits at the depth it entered with.
        if (grant_any) begin
          state_d = ST_RUN;
        end else if (cfg_depth != active_depth_q) begin
          active_depth_d = cfg_depth;
        end
      end
      ST_RUN: begin
        if (cfg_depth != active_depth_q) begin
          state_d = ST_DRAIN;
        end else if ((occ == 3'd0) && !grant_any) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (occ == 3'd0) begin
          active_depth_d = cfg_depth;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < STAGES; k++) begin
        s_q[k] <= '0;
      end
      state_q        <= ST_IDLE;
      rr_ptr_q       <= 1'b0;
      active_depth_q <= 2'd3;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        s_q[k] <= s_d[k];
      end
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      active_depth_q <= active_depth_d;
    end
  end

endmodule

// File: tb/tb_dff_link_arbiter.sv
// Directed scoreboard bench for dff_link_arbiter.
// Stimulus queues the expected bytes and delivery cycles, and a forked monitor retires them.
module tb_dff_link_arbiter;

  logic       clk;
  logic       RST;
  logic [1:0] cfg_depth;
  logic       flush;
  logic [1:0] active_depth;
  logic [2:0] occupancy;
  logic       busy;

  dff_link_arbiter_if #(.WIDTH(8)) link_if ();

  dff_link_arbiter #(.WIDTH(8), .STAGES(4)) dut (
    .CLK          (clk),
    .RST          (RST),
    .link         (link_if),
    .cfg_depth    (cfg_depth),
    .flush        (flush),
    .active_depth (active_depth),
    .occupancy    (occupancy),
    .busy         (busy)
  );

  typedef struct {
    logic       src;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   base;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic src, input logic [7:0] data, input int at);
    exp_t e;
    e.src  = src;
    e.data = data;
    e.at   = at;
    q.push_back(e);
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 60 && q.size() > 0; i++) step();
    chk({name, "_drain_left"}, q.size(), 0);
    step();
    step();
  endtask

  task automatic set_req(input logic av, input logic [7:0] ad, input logic bv, input logic [7:0] bd);
    link_if.a_valid = av;
    link_if.a_data  = ad;
    link_if.b_valid = bv;
    link_if.b_data  = bd;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_out_valid"}, link_if.out_valid, 0);
    chk({name, "_out_data"}, link_if.out_data, 0);
    chk({name, "_out_src"}, link_if.out_src, 0);
    chk({name, "_active_depth"}, active_depth, 3);
    chk({name, "_occupancy"}, occupancy, 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  initial begin
    RST = 1'b1;
    flush = 1'b0;
    cfg_depth = 2'd3;
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    link_if.out_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!RST && link_if.out_valid === 1'b1 && link_if.out_ready === 1'b1) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_out: got data 0x%0h src %0d, expected no transfer (cycle %0d)",
                     link_if.out_data, link_if.out_src, cyc);
          end else begin
            mon_e = q.pop_front();
            $display("[TB] out cyc=%0d data=0x%02h src=%0d", cyc, link_if.out_data, link_if.out_src);
            chk("out_data", link_if.out_data, mon_e.data);
            chk("out_src", link_if.out_src, mon_e.src);
            chk("out_cycle", cyc, mon_e.at);
          end
        end
      end
    join_none

    // Reset held for two edges
    step();
    step();
    chk_reset_outputs("reset");
    chk("reset_a_ready", link_if.a_ready, 0);
    chk("reset_b_ready", link_if.b_ready, 0);
    RST = 1'b0;

    // Single request: visible four cycles after acceptance at depth 3
    link_if.out_ready = 1'b1;
    set_req(1'b1, 8'h5A, 1'b0, 8'h00);
    #1;
    chk("single_a_ready", link_if.a_ready, 1);
    push(1'b0, 8'h5A, cyc + 4);
    step();
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    wait_empty("single");

    // Round-robin from a fresh pointer
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, 8'h11, 1'b1, 8'h22);
      #1;
      chk("rr_a_ready", link_if.a_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_b_ready", link_if.b_ready, (i % 2 == 0) ? 0 : 1);
      if (i % 2 == 0) push(1'b0, 8'h11, cyc + 4);
      else            push(1'b1, 8'h22, cyc + 4);
      step();
    end
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    wait_empty("rr");

    // Back-pressure: three stall cycles while byte 1 sits at the tap
    base = cyc;
    for (int i = 0; i < 6; i++) push(1'b0, 8'(i + 1), base + 7 + i);
    for (int k = 0; k < 10; k++) begin
      logic [7:0] d;
      d = (k < 4) ? 8'(k + 1) : (k < 7) ? 8'd5 : 8'(k - 2);
      set_req(k <= 8, d, 1'b0, 8'h00);
      link_if.out_ready = !(k >= 4 && k <= 6);
      #1;
      chk("bp_a_ready", link_if.a_ready, (k <= 3 || k == 7 || k == 8) ? 1 : 0);
      if (k >= 4 && k <= 6) begin
        chk("bp_stall_valid", link_if.out_valid, 1);
        chk("bp_stall_data", link_if.out_data, 8'h01);
      end
      if (k == 4) chk("bp_occupancy_peak", occupancy, 4);
      step();
    end
    link_if.out_ready = 1'b1;
    wait_empty("bp");

    // Depth change 3 -> 0 during RUN
    base = cyc;
    push(1'b0, 8'hA1, base + 4);
    push(1'b0, 8'hA2, base + 5);
    push(1'b0, 8'hA3, base + 8);
    for (int k = 0; k < 9; k++) begin
      logic [7:0] d;
      d = (k == 0) ? 8'hA1 : (k == 1) ? 8'hA2 : 8'hA3;
      set_req(k <= 7, d, 1'b0, 8'h00);
      if (k == 1) cfg_depth = 2'd0;
      #1;
      if (k <= 7) chk("depth_a_ready", link_if.a_ready, (k <= 1 || k == 7) ? 1 : 0);
      if (k == 2) chk("depth_busy_drain", busy, 1);
      if (k == 6) chk("depth_active_old", active_depth, 3);
      if (k == 7) chk("depth_active_new", active_depth, 0);
      step();
    end
    wait_empty("depth");

    // Flush with three bytes in flight; pointer must survive it
    cfg_depth = 2'd3;
    step();
    chk("flush_depth_restored", active_depth, 3);
    for (int k = 0; k < 6; k++) begin
      set_req(k <= 4, 8'h31, (k <= 4) && (k != 2), 8'h32);
      flush = (k == 3);
      #1;
      if (k == 0) chk("flush_b_first", link_if.b_ready, 1);
      if (k == 1) chk("flush_a_second", link_if.a_ready, 1);
      if (k == 2) chk("flush_a_alone", link_if.a_ready, 1);
      if (k == 3) begin
        chk("flush_a_ready", link_if.a_ready, 0);
        chk("flush_b_ready", link_if.b_ready, 0);
      end
      if (k == 4) begin
        chk("flush_out_valid", link_if.out_valid, 0);
        chk("flush_occupancy", occupancy, 0);
        chk("flush_busy", busy, 0);
        chk("flush_rr_b_ready", link_if.b_ready, 1);
        chk("flush_rr_a_ready", link_if.a_ready, 0);
        push(1'b1, 8'h32, cyc + 4);
      end
      step();
    end
    flush = 1'b0;
    wait_empty("flush");

    // Reset during a stall with the link full at depth 1
    cfg_depth = 2'd1;
    step();
    chk("rst_depth_one", active_depth, 1);
    for (int k = 0; k < 5; k++) begin
      set_req(k <= 1 || k == 3, (k == 0) ? 8'h41 : 8'h42, 1'b0, 8'h00);
      link_if.out_ready = (k <= 1);
      RST = (k == 3);
      #1;
      if (k <= 1) chk("rst_fill_a_ready", link_if.a_ready, 1);
      if (k == 2) begin
        chk("rst_stall_valid", link_if.out_valid, 1);
        chk("rst_stall_data", link_if.out_data, 8'h41);
        chk("rst_full_occupancy", occupancy, 2);
      end
      if (k == 3) chk("rst_a_ready", link_if.a_ready, 0);
      if (k == 4) chk_reset_outputs("rst_mid");
      step();
    end
    chk("final_queue", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dff_link_arbiter.md
# dff_link_arbiter

Shares one 4-stage, 8-bit DFF delay link between two requesters (A and B) through a round-robin arbiter. Each accepted byte carries a valid bit and a source tag down the link. The block delivers it on a valid/ready output port after a programmable depth of 1–4 stages, with full-link back-pressure. It sits in front of the DFF link datapath and owns its sequencing, sharing and depth configuration.

## Interface
- Parameters:
  - WIDTH, 8, data width per stage.
  - STAGES, 4, physical link stages. Fixed at 4; cfg_depth decoding assumes 4.
- Ports:
  - CLK  input  1  clock, rising edge.
  - RST  input  1  reset, synchronous, active-high.
  - a_valid / b_valid  input  1  requester has a byte.
  - a_data / b_data  input  WIDTH  requester byte.
  - a_ready / b_ready  output  1  byte accepted this cycle (grant).
  - cfg_depth  input  2  requested depth minus 1 (0 = 1 stage … 3 = 4 stages).
  - flush  input  1  synchronous clear of link contents.
  - out_valid  output  1  byte available at the active tap.
  - out_ready  input  1  downstream accepts.
  - out_data  output  WIDTH  byte at the tap.
  - out_src  output  1  source tag: 0 = A, 1 = B.
  - active_depth  output  2  depth currently in force.
  - occupancy  output  3  count of valid stages 0..active_depth.
  - busy  output  1  state != IDLE.

## Operation
- Link storage: stage s[k] = {v, src, data}, k = 0..3. The tap is s[active_depth]. out_valid/out_data/out_src come directly from the tap registers. Valid bits beyond the tap are held 0.
- advance = !(s[tap].v && !out_ready). On advance, s[0] loads the grant result (v = grant), and s[k] <= s[k-1] for 1 ≤ k ≤ tap. On no advance, all stages hold.
- Arbitration:
  - Grants are issued only when advance && state != DRAIN && !flush. At most one grant per cycle.
  - If only one requester is valid, it wins.
  - If both are valid, the requester pointed to by rr_ptr wins.
  - After any grant, rr_ptr points to the loser.
  - a_ready = grant_a and b_ready = grant_b, combinational.
- FSM:
  - IDLE: link empty. A grant moves the FSM to RUN. cfg_depth != active_depth loads active_depth immediately and stays in IDLE.
  - RUN: on occupancy reaching 0 with no grant this cycle, go to IDLE. On cfg_depth != active_depth, go to DRAIN.
  - DRAIN: no grants; the link keeps shifting and delivering. When occupancy == 0, load active_depth <= cfg_depth and go to IDLE.
- Flush:
  - All v <= 0 and the FSM goes to IDLE. rr_ptr and active_depth are unchanged.
  - Ready outputs are 0 in the flush cycle.
  - Any out handshake in that cycle is still counted as a transfer of the presented byte.
- Reset (RST high at an edge): all v = 0, data = 0, FSM = IDLE, rr_ptr = A, active_depth = 3. RST overrides flush and all handshakes, including mid-transfer.

## Timing
- Reset values: a_ready = b_ready = 0, out_valid = 0, out_data = 0, out_src = 0, active_depth = 3, occupancy = 0, busy = 0.
- Latency: a byte accepted in cycle N is presented at out_valid in cycle N + active_depth + 1, with no stalls.
- Throughput: 1 byte/cycle when out_ready is held high.
- Stall: out_valid && !out_ready freezes the whole link. out_data is stable until accepted, and grants are 0 during the stall.
- A depth change takes effect the cycle after the FSM leaves DRAIN (or IDLE). In-flight bytes always exit at the depth they entered with.
- Simultaneous events:
  - Grant and tap consume in the same cycle: occupancy stays unchanged.
  - flush and RST together: RST wins.
  - cfg_depth toggling back to active_depth during DRAIN: DRAIN still completes. The reloaded value is the cfg_depth sampled at the exit cycle.
- occupancy and busy are registered-state derived, with no combinational path from inputs.

## Test plan
- Reset then single request:
  - Stimulus: RST high 2 cycles; then a_valid = 1, a_data = 0x5A for 1 cycle; out_ready = 1.
  - Response: out_valid = 1 exactly 4 cycles later, with out_data = 0x5A and out_src = 0.
- Round-robin:
  - Stimulus: both requesters valid continuously, A = 0x11, B = 0x22, out_ready = 1.
  - Response: grants alternate A, B, A, B starting with A; output sequence 0x11, 0x22, 0x11, …
- Back-pressure:
  - Stimulus: stream A bytes 0x01..0x06; drop out_ready for 3 cycles while out_valid = 1.
  - Response: out_data held; a_ready = 0 during the stall; no byte lost or duplicated; occupancy peaks at 4.
- Depth change:
  - Stimulus: while in RUN at depth 3, set cfg_depth = 0.
  - Response: FSM goes to DRAIN and grants stop. The remaining bytes exit at 4-cycle latency. active_depth becomes 0, and the next byte has 1-cycle latency.
- Flush mid-stream:
  - Stimulus: 3 bytes in flight; pulse flush for 1 cycle.
  - Response: out_valid = 0 and occupancy = 0 next cycle; busy = 0; rr_ptr is preserved on the next contention.
- Reset mid-operation:
  - Stimulus: assert RST during a stall with the link full.
  - Response: all outputs return to their reset values next cycle; active_depth = 3.
